// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the push-button front end: debounce FSM encoding,
// key index map and default timing.
package key_pulse_gen_pkg;

    // Debounce FSM states, one FSM per key.
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Bit positions on keys_in / key_level.
    localparam int NUM_KEYS    = 6;
    localparam int KEY_RESTART = 0;
    localparam int KEY_LEFT    = 1;
    localparam int KEY_RIGHT   = 2;
    localparam int KEY_UP      = 3;
    localparam int KEY_DOWN    = 4;
    localparam int KEY_CHANGE  = 5;

    // 20 ms of stable level at 50 MHz.
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int CNT_W_DEF      = 20;

    // A key counts as held once a press is accepted and until the release
    // is confirmed, so the release-wait state still reports "held".
    function automatic logic is_held(input logic [1:0] st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_pulse_gen_key_filter.sv
// Single-key conditioner: 2-flop synchronizer, debounce FSM with a stable-level
// counter, one-cycle press pulse and a debounced held level.
//
// Handshake: none. press_pulse is a registered strobe, high for exactly one
// clock per accepted press; level is a registered copy of the debounced state.
module key_filter
    import key_pulse_gen_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    output logic       press_pulse,
    output logic       level,
    output logic [1:0] state_dbg
);

    localparam logic             IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             pressed;

    // Synchronizer next values; polarity is resolved only after the second flop.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce FSM: a level must stay stable for DEB_CYCLES counted cycles
    // before the state flips; any disagreeing sample restarts the wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (pressed) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!pressed) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
        level_d = is_held(state_d);
    end

    // All state of this key; synchronizer resets to the idle pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign press_pulse = pulse_q;
    assign level       = level_q;
    assign state_dbg   = state_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Six-button front end for the vision-test display: per-key debounce, then a
// one-hot priority arbiter over the four direction keys and an output register.
// Restart and change bypass the arbiter and may fire alongside anything.
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic                RESTARTdown,
    output logic                LeftDown,
    output logic                RightDown,
    output logic                upDown,
    output logic                DownDown,
    output logic                ChangeDown,
    output logic [NUM_KEYS-1:0] key_level
);

    logic [NUM_KEYS-1:0] raw_pulse;
    logic [NUM_KEYS-1:0] level_w;
    logic [1:0]          state_w [NUM_KEYS];
    logic [NUM_KEYS-1:0] pulse_q, pulse_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_filter #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_filter (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (keys_in[i]),
            .press_pulse (raw_pulse[i]),
            .level       (level_w[i]),
            .state_dbg   (state_w[i])
        );

        // The held level must always agree with the FSM state it came from.
        a_level_state: assert property (@(posedge clk) disable iff (rst)
            level_w[i] == is_held(state_w[i]));
    end

    // Direction arbiter: left > right > up > down; losers are dropped, not queued.
    always_comb begin
        pulse_d = raw_pulse;
        if (raw_pulse[KEY_LEFT]) begin
            pulse_d[KEY_RIGHT] = 1'b0;
            pulse_d[KEY_UP]    = 1'b0;
            pulse_d[KEY_DOWN]  = 1'b0;
        end else if (raw_pulse[KEY_RIGHT]) begin
            pulse_d[KEY_UP]    = 1'b0;
            pulse_d[KEY_DOWN]  = 1'b0;
        end else if (raw_pulse[KEY_UP]) begin
            pulse_d[KEY_DOWN]  = 1'b0;
        end
    end

    // Output pulse register; async reset drops any pulse in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    // The display block relies on never seeing two directions at once.
    a_dir_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(pulse_q[KEY_DOWN:KEY_LEFT]));

    assign RESTARTdown = pulse_q[KEY_RESTART];
    assign LeftDown    = pulse_q[KEY_LEFT];
    assign RightDown   = pulse_q[KEY_RIGHT];
    assign upDown      = pulse_q[KEY_UP];
    assign DownDown    = pulse_q[KEY_DOWN];
    assign ChangeDown  = pulse_q[KEY_CHANGE];
    assign key_level   = level_w;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen with DEB_CYCLES=8, active-low buttons.
// Reference model: a key's debounced level flips once the sampled pin has
// disagreed with it for DEB+1 consecutive clock samples (the first sample
// opens the wait, then DEB counted samples). Level shows 2 edges after that
// sample (synchronizer), the press pulse 3 edges after (plus output flop).
`timescale 1ns/1ps
module tb_key_pulse_gen;
    import key_pulse_gen_pkg::*;

    localparam int DEB  = 8;
    localparam int MAXC = 20000;
    localparam int EW   = 38; // {due cycle[31:0], pulse vector[5:0]}

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] keys_in = 6'h3F;
    logic       RESTARTdown, LeftDown, RightDown, upDown, DownDown, ChangeDown;
    logic [5:0] key_level;

    always #5 clk = ~clk;

    key_pulse_gen #(
        .DEB_CYCLES (DEB),
        .CNT_W      (20),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keys_in     (keys_in),
        .RESTARTdown (RESTARTdown),
        .LeftDown    (LeftDown),
        .RightDown   (RightDown),
        .upDown      (upDown),
        .DownDown    (DownDown),
        .ChangeDown  (ChangeDown),
        .key_level   (key_level)
    );

    // ---------------- scoreboard state ----------------
    int cyc    = -1;
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [5:0]    lvl_hist [MAXC+16];
    logic [5:0]    m_level = '0;
    int            m_run [6];
    int            obs_cnt [6];
    int            base [6];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model, one call per rising edge.
    task automatic model_step();
        logic [5:0] pressed;
        logic [5:0] rise;
        logic [5:0] win;
        cyc++;
        if (rst) begin
            m_level = '0;
            for (int i = 0; i < 6; i++) m_run[i] = 0;
            exp_q.delete();
            for (int k = 0; k < 3; k++) if (cyc - k >= 0) lvl_hist[cyc-k] = '0;
        end else begin
            pressed = ~keys_in;
            rise    = '0;
            for (int i = 0; i < 6; i++) begin
                if (pressed[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_level[i] = pressed[i];
                        m_run[i]   = 0;
                        rise[i]    = pressed[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            win = rise & ((6'b1 << KEY_RESTART) | (6'b1 << KEY_CHANGE));
            for (int k = KEY_LEFT; k <= KEY_DOWN; k++) begin
                if (rise[k]) begin
                    win[k] = 1'b1;
                    break;
                end
            end
            if (win != '0) exp_q.push_back({32'(cyc + 3), win});
            lvl_hist[cyc] = m_level;
        end
    endtask

    // Monitor, one call per falling edge.
    task automatic monitor_step();
        logic [5:0]    obs;
        logic [5:0]    exp_p;
        logic [EW-1:0] head;
        obs = {ChangeDown, DownDown, upDown, RightDown, LeftDown, RESTARTdown};
        for (int i = 0; i < 6; i++) obs_cnt[i] += int'(obs[i]);
        if (rst) begin
            check("reset_outputs", {obs, key_level}, 12'h000);
            while (exp_q.size() > 0 && int'(exp_q[0][37:6]) <= cyc) void'(exp_q.pop_front());
        end else begin
            exp_p = '0;
            while (exp_q.size() > 0 && int'(exp_q[0][37:6]) < cyc) begin
                head = exp_q.pop_front();
                check("missed_pulse", 12'h000, {6'h0, head[5:0]});
            end
            if (exp_q.size() > 0 && int'(exp_q[0][37:6]) == cyc) begin
                head  = exp_q.pop_front();
                exp_p = head[5:0];
            end
            check("pulse", {6'h0, obs}, {6'h0, exp_p});
            check("key_level", {6'h0, key_level}, {6'h0, (cyc >= 2) ? lvl_hist[cyc-2] : 6'h0});
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cyc >= 0) monitor_step();
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // mask bits = buttons held down (pins driven low)
    task automatic press(input logic [5:0] mask, input int n);
        keys_in = ~mask;
        wait_cycles(n);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (n) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 6; i++) base[i] = obs_cnt[i];
    endtask

    task automatic expect_counts(input string tag, input logic [5:0] ones);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_count_k%0d", tag, i), 12'(obs_cnt[i] - base[i]), {11'h0, ones[i]});
    endtask

    task automatic report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] flip;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;

        snap(); press(6'b000010, 50); press(6'b0, 25);
        expect_counts("clean_press", 6'b000010);

        snap();
        for (int r = 0; r < 5; r++) begin press(6'b001000, 3); press(6'b0, 3); end
        press(6'b0, 25);
        expect_counts("bounce_high", 6'b000000);

        snap();
        for (int r = 0; r < 5; r++) begin press(6'b001000, 3); press(6'b0, 3); end
        press(6'b001000, 30); press(6'b0, 25);
        expect_counts("bounce_low", 6'b001000);

        snap(); press(6'b010100, 30); press(6'b0, 25);
        expect_counts("arbitration", 6'b000100);

        snap(); press(6'b100011, 30); press(6'b0, 25);
        expect_counts("simultaneous", 6'b100011);

        snap(); press(6'b100000, 6); do_reset(2); press(6'b100000, 30); press(6'b0, 25);
        expect_counts("reset_mid", 6'b100000);

        snap(); press(6'b000010, 40); press(6'b0, 3); press(6'b000010, 30); press(6'b0, 25);
        expect_counts("release_bounce", 6'b000010);

        for (int n = 0; n < 300; n++) begin
            flip    = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
            keys_in = keys_in ^ flip;
            wait_cycles($urandom_range(1, 14));
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
        end

        keys_in = 6'h3F;
        wait_cycles(30);
        check("drain", 12'(exp_q.size()), 12'h000);
        report();
        $finish;
    end

    initial begin
        #190000;
        errors++;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        report();
        $finish;
    end

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Upstream input stage for the vision-test display block.
- Takes six raw mechanical push-buttons and turns each into a single-clock-cycle press pulse:
  - restart, left, right, up, down, change.
- Per button: 2-flop synchronizer, debounce FSM.
- The four direction pulses then pass through a one-hot priority arbiter, so the display block never sees two direction keys in the same cycle.

Parameters:
- DEB_CYCLES, 1000000, stable-level cycles needed to accept a press or release (20 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each debounce counter.
- ACTIVE_LOW, 1, 1 = a pressed button reads 0 on keys_in; 0 = pressed reads 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- keys_in  input  6  raw buttons, asynchronous to clk; bit map: [0] restart, [1] left, [2] right, [3] up, [4] down, [5] change
- RESTARTdown  output  1  one-cycle press pulse, restart
- LeftDown  output  1  one-cycle press pulse, left (arbitrated)
- RightDown  output  1  one-cycle press pulse, right (arbitrated)
- upDown  output  1  one-cycle press pulse, up (arbitrated)
- DownDown  output  1  one-cycle press pulse, down (arbitrated)
- ChangeDown  output  1  one-cycle press pulse, change
- key_level  output  6  debounced held state per key, 1 = pressed, same bit map as keys_in

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Every flop clears on rst.
- Reset values:
  - All pulse outputs = 0; key_level = 6'b0.
  - Every FSM in RELEASED; every counter = 0.
  - Synchronizer flops = the inactive level (1 if ACTIVE_LOW, else 0).
- Synchronizer: two flops per key. ACTIVE_LOW inversion is applied after the second flop, giving an internal "pressed" level p.
- Per-key FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: p=1 → PRESS_WAIT, cnt=0.
  - PRESS_WAIT: p=0 → RELEASED (bounce, cnt cleared). Otherwise cnt++; when cnt==DEB_CYCLES-1 → PRESSED and raw pulse asserted for that one cycle.
  - PRESSED: p=0 → RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: p=1 → PRESSED (bounce). Otherwise cnt++; when cnt==DEB_CYCLES-1 → RELEASED. No pulse is ever generated on release.
- key_level[i] = 1 while FSM i is in PRESSED or RELEASE_WAIT.
- Pulse timing: the raw pulse is registered into the output flop.
  - Latency from the first stable pressed sample on keys_in to the output pulse = 2 (sync) + DEB_CYCLES + 1 (output register) cycles.
  - The pulse is exactly 1 cycle wide.
  - Exactly one pulse per accepted press, regardless of hold time. No auto-repeat.
- Direction arbitration (combinational on the raw pulses, before the output register):
  - Priority left > right > up > down.
  - Lower-priority pulses in the same cycle are dropped, not deferred.
  - restart and change are never arbitrated and may coincide with each other or with a direction pulse.
- Counter width: cnt saturates logically because the FSM exits at DEB_CYCLES-1. It never wraps.
- Key held through reset deassertion: treated as a fresh press; one pulse appears 2+DEB_CYCLES+1 cycles after rst falls.
- rst asserted mid-debounce or mid-pulse: pulse drops immediately (async). No pulse is emitted after rst falls unless the key is still held (rule above).
- Glitch shorter than DEB_CYCLES: no pulse, no key_level change.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (2-bit, RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3);
  - key index constants (KEY_RESTART=0 … KEY_CHANGE=5);
  - default DEB_CYCLES.
- One sub-module, key_filter: synchronizer + FSM + counter for a single key. It outputs a raw one-cycle pulse and a level.
- key_pulse_gen instantiates six key_filter, plus the arbiter and output registers.

Test Plan (DEB_CYCLES=8, ACTIVE_LOW=1):
- Clean press: keys_in[1] driven low and held 50 cycles → LeftDown=1 for exactly 1 cycle, 11 cycles after the falling edge; key_level[1]=1 until 2+8 cycles after release; no further pulse.
- Bounce: keys_in[3] toggles low/high every 3 cycles for 30 cycles, then returns high → upDown never asserts, key_level[3] stays 0. The same sequence ending in a stable low → exactly one upDown pulse, 11 cycles after the last edge.
- Arbitration: keys_in[2] and keys_in[4] go low in the same cycle → RightDown pulses once; DownDown stays 0 throughout, including after release.
- Independent keys: keys_in[0] and keys_in[5] low in the same cycle as keys_in[1] → RESTARTdown, ChangeDown and LeftDown all pulse in the same cycle.
- Reset mid-debounce: keys_in[5] low; rst pulsed at cycle 6 with the key still held → no ChangeDown before rst falls; exactly one ChangeDown 11 cycles after rst deasserts.
- Release bounce: key held 40 cycles, then a 3-cycle high glitch, then held → key_level stays 1 and no second pulse.
